// File: rtl/button_debouncer.sv
// Multi-channel button debouncer: 2-flop synchronizer plus a per-channel 4-state FSM with a stability counter.
// Define DEBOUNCE_CHANGE_FLAG_EN to add the btn_chg one-cycle toggle strobe output.
module button_debouncer #(
  parameter int WIDTH   = 5,
  parameter int CNT_MAX = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn_db
`ifdef DEBOUNCE_CHANGE_FLAG_EN
  ,
  output logic [WIDTH-1:0] btn_chg
`endif
);

  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_e;

  logic [WIDTH-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      db_d    = db_q;
      case (state_q)
        STABLE_LO: begin
          if (sync2_q[i]) begin
            state_d = WAIT_HI;
            cnt_d   = '0;
          end
        end
        WAIT_HI: begin
          if (!sync2_q[i]) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
            db_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        STABLE_HI: begin
          if (!sync2_q[i]) begin
            state_d = WAIT_LO;
            cnt_d   = '0;
          end
        end
        WAIT_LO: begin
          if (sync2_q[i]) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
            db_d    = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          db_d    = 1'b0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= STABLE_LO;
        cnt_q   <= '0;
        db_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        db_q    <= db_d;
      end
    end

    assign btn_db[i] = db_q;

`ifdef DEBOUNCE_CHANGE_FLAG_EN
    // Registered alongside db_q so the strobe lines up with the cycle btn_db shows its new value.
    logic chg_q, chg_d;

    always_comb chg_d = db_d ^ db_q;

    always_ff @(posedge clk) begin
      if (reset) chg_q <= 1'b0;
      else       chg_q <= chg_d;
    end

    assign btn_chg[i] = chg_q;
`endif
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer (WIDTH=2, CNT_MAX=4) plus a CNT_MAX=1 instance for the minimum-latency case.
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] btn_in = 2'b00;
  logic [1:0] btn_db;
  logic [0:0] btn_db1;
`ifdef DEBOUNCE_CHANGE_FLAG_EN
  logic [1:0] btn_chg;
  logic [0:0] btn_chg1;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         e;
    logic [1:0] db;
    logic [1:0] chg;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  button_debouncer #(.WIDTH(2), .CNT_MAX(4)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .btn_db(btn_db)
`ifdef DEBOUNCE_CHANGE_FLAG_EN
    , .btn_chg(btn_chg)
`endif
  );

  button_debouncer #(.WIDTH(1), .CNT_MAX(1)) dut1 (
    .clk(clk), .reset(reset), .btn_in(btn_in[0:0]), .btn_db(btn_db1)
`ifdef DEBOUNCE_CHANGE_FLAG_EN
    , .btn_chg(btn_chg1)
`endif
  );

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic drive(input logic [1:0] b, input logic r);
    @(negedge clk);
    btn_in = b;
    reset  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t x;
    for (int e = 1; e <= 14; e++) begin
      sb.push_back('{e, (e >= 10) ? 2'b11 : 2'b00, (e == 10) ? 2'b11 : 2'b00});
      drive(2'b11, e <= 3);
      x = sb.pop_front();
      total++;
      if (btn_db !== x.db) begin
        bad++;
        $display("FAIL reset_db edge=%0d got=%b exp=%b", x.e, btn_db, x.db);
      end
`ifdef DEBOUNCE_CHANGE_FLAG_EN
      total++;
      if (btn_chg !== x.chg) begin
        bad++;
        $display("FAIL reset_chg edge=%0d got=%b exp=%b", x.e, btn_chg, x.chg);
      end
`endif
    end
  endtask

  task automatic test_clean_press();
    exp_t x;
    logic exp1;
    for (int e = 1; e <= 22; e++) begin
      sb.push_back('{e, {1'b0, e >= 16}, {1'b0, e == 16}});
      exp1 = (e >= 13);
      drive({1'b0, e >= 10}, e <= 2);
      x = sb.pop_front();
      total++;
      if (btn_db !== x.db) begin
        bad++;
        $display("FAIL clean_press_db edge=%0d got=%b exp=%b", x.e, btn_db, x.db);
      end
      total++;
      if (btn_db1[0] !== exp1) begin
        bad++;
        $display("FAIL cnt_max1_db edge=%0d got=%b exp=%b", x.e, btn_db1[0], exp1);
      end
`ifdef DEBOUNCE_CHANGE_FLAG_EN
      total++;
      if (btn_chg !== x.chg) begin
        bad++;
        $display("FAIL clean_press_chg edge=%0d got=%b exp=%b", x.e, btn_chg, x.chg);
      end
      total++;
      if (btn_chg1[0] !== (e == 13)) begin
        bad++;
        $display("FAIL cnt_max1_chg edge=%0d got=%b exp=%b", x.e, btn_chg1[0], e == 13);
      end
`endif
    end
  endtask

  task automatic test_bounce();
    exp_t x;
    logic b0;
    for (int e = 1; e <= 30; e++) begin
      b0 = (e == 16) || (e == 18) || (e >= 20);
      sb.push_back('{e, {1'b0, e >= 26}, {1'b0, e == 26}});
      drive({1'b0, b0}, e <= 2);
      x = sb.pop_front();
      total++;
      if (btn_db !== x.db) begin
        bad++;
        $display("FAIL bounce_db edge=%0d got=%b exp=%b", x.e, btn_db, x.db);
      end
`ifdef DEBOUNCE_CHANGE_FLAG_EN
      total++;
      if (btn_chg !== x.chg) begin
        bad++;
        $display("FAIL bounce_chg edge=%0d got=%b exp=%b", x.e, btn_chg, x.chg);
      end
`endif
    end
  endtask

  // 3- and 4-cycle low pulses must be ignored; a 5-cycle low pulse is accepted.
  task automatic test_glitch();
    exp_t x;
    logic b1, d1;
    for (int e = 1; e <= 40; e++) begin
      b1 = (e >= 3) && !(e >= 12 && e <= 14) && !(e >= 18 && e <= 21) && !(e >= 26 && e <= 30);
      d1 = (e >= 9 && e < 32) || (e >= 37);
      sb.push_back('{e, {d1, 1'b0}, {(e == 9) || (e == 32) || (e == 37), 1'b0}});
      drive({b1, 1'b0}, e <= 2);
      x = sb.pop_front();
      total++;
      if (btn_db !== x.db) begin
        bad++;
        $display("FAIL glitch_db edge=%0d got=%b exp=%b", x.e, btn_db, x.db);
      end
`ifdef DEBOUNCE_CHANGE_FLAG_EN
      total++;
      if (btn_chg !== x.chg) begin
        bad++;
        $display("FAIL glitch_chg edge=%0d got=%b exp=%b", x.e, btn_chg, x.chg);
      end
`endif
    end
  endtask

  task automatic test_reset_mid_wait();
    exp_t x;
    for (int e = 1; e <= 24; e++) begin
      sb.push_back('{e, {1'b0, e >= 20}, {1'b0, e == 20}});
      drive({1'b0, e >= 10}, (e <= 2) || (e == 13));
      x = sb.pop_front();
      total++;
      if (btn_db !== x.db) begin
        bad++;
        $display("FAIL reset_mid_wait_db edge=%0d got=%b exp=%b", x.e, btn_db, x.db);
      end
`ifdef DEBOUNCE_CHANGE_FLAG_EN
      total++;
      if (btn_chg !== x.chg) begin
        bad++;
        $display("FAIL reset_mid_wait_chg edge=%0d got=%b exp=%b", x.e, btn_chg, x.chg);
      end
`endif
    end
  endtask

  task automatic test_independence();
    exp_t x;
    for (int e = 1; e <= 42; e++) begin
      sb.push_back('{e, {e >= 39, e >= 36}, {e == 39, e == 36}});
      drive({(e >= 30) && (e != 32), e >= 30}, e <= 2);
      x = sb.pop_front();
      total++;
      if (btn_db !== x.db) begin
        bad++;
        $display("FAIL independence_db edge=%0d got=%b exp=%b", x.e, btn_db, x.db);
      end
`ifdef DEBOUNCE_CHANGE_FLAG_EN
      total++;
      if (btn_chg !== x.chg) begin
        bad++;
        $display("FAIL independence_chg edge=%0d got=%b exp=%b", x.e, btn_chg, x.chg);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_reset_mid_wait();
    test_independence();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
